dlx_bus_slave: RTL and testbench
================================

Name: dlx_bus_slave

Overview:
- Bus responder for the DLX master's asynchronous-handshake memory bus (AS_N / WR_N / ACK_N).
- Decodes a configurable address window and serves reads and writes from an internal word-addressed register file.
- Inserts a programmable number of wait states before acknowledging.
- Sits beside the DLX core in the IO simulation top level; it is the far end of the master's bus cycle.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width.
- BASE_ADDR, 32'h0000_0000, first word address of the decoded window.
- DEPTH_LOG2, 5, log2 of number of words held (window size = 2**DEPTH_LOG2).
- WAIT_STATES, 2, idle cycles between request capture and ACK_N assertion; legal range 0..15.

Ports:
- CLK_IN  input  1  system clock; all state changes on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- AS_N  input  1  address strobe from master; active low.
- WR_N  input  1  0 = write, 1 = read; valid while AS_N low.
- ADDR  input  ADDR_W  word address from master; stable while AS_N low.
- DI  input  DATA_W  write data from master; stable while AS_N low.
- DO  output  DATA_W  read data to master; valid while ACK_N low.
- ACK_N  output  1  acknowledge to master; active low, one cycle.
- BUSY  output  1  high from request capture until return to IDLE.
- DBG_ADDR  input  DEPTH_LOG2  bench/monitor peek index.
- DBG_DATA  output  DATA_W  combinational content of word DBG_ADDR.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - ACK_N=1, BUSY=0, DO=0, state=IDLE, wait counter=0.
  - Memory contents are not cleared.
- Hit condition: ADDR - BASE_ADDR < 2**DEPTH_LOG2, computed unsigned at ADDR_W bits. Index = low DEPTH_LOG2 bits of (ADDR - BASE_ADDR).
- Master contract:
  - Holds AS_N low with ADDR/WR_N/DI stable until it samples ACK_N low.
  - Raises AS_N in the cycle after the ACK.
- State machine (one-hot or encoded, implementer's choice): IDLE, WAIT, ACK, DONE.
  - IDLE: on rising edge with AS_N=0 and hit, latch index and WR_N, BUSY<=1.
    - WAIT_STATES=0: go to ACK.
    - Otherwise: load counter with WAIT_STATES and go to WAIT.
    - A miss stays in IDLE with no response, so another slave may answer.
  - WAIT: decrement counter; when counter reaches 1, go to ACK. Exactly WAIT_STATES cycles are spent in WAIT.
  - ACK: ACK_N=0 for exactly one cycle.
    - Read: DO = mem[index], registered on entry to ACK.
    - Write: mem[index] <= DI on the ACK-exit edge.
    - Then go to DONE.
  - DONE: ACK_N=1. Wait for AS_N=1, then go to IDLE and set BUSY<=0. DONE is never re-acknowledged while AS_N stays low.
- Latency:
  - AS_N sampled low at edge N gives ACK_N low during cycle N+1+WAIT_STATES.
  - Back-to-back transactions need at least one cycle with AS_N high.
- DO holds its last read value outside ACK; it is not zeroed.
- Abandoned cycle: AS_N rising during WAIT aborts the transaction. Return to IDLE, no ACK, no write.
- DBG_DATA is a pure combinational read and has no effect on the bus.
- Reset mid-transaction: immediate return to IDLE; any pending write is discarded.
- Address wrap: BASE_ADDR near 2**ADDR_W - 1 uses the unsigned subtraction rule; no special-casing.

Decomposition:
- Shared package dlx_bus_pkg holds:
  - State enum (IDLE, WAIT, ACK, DONE).
  - Bus width constants (ADDR_W, DATA_W defaults).
  - WAIT_STATES maximum (15).
- One sub-module is natural: dlx_bus_regfile, a DEPTH-word array with a synchronous write port, one synchronous read port for DO, and one combinational read port for DBG.

Test Plan:
- Write then read, WAIT_STATES=2, BASE=0:
  - Write DI=32'hDEAD_BEEF to ADDR=3 -> ACK_N low exactly 3 cycles after AS_N sampled low; DBG_ADDR=3 shows DEAD_BEEF.
  - Read ADDR=3 -> DO=DEAD_BEEF during the ACK cycle.
- Zero wait states (WAIT_STATES=0) -> ACK_N low in the cycle immediately after AS_N sampled low; write of 32'h1 to ADDR=0 lands.
- Window miss, BASE=32'h100, DEPTH_LOG2=5:
  - AS_N low with ADDR=32'h120 for 10 cycles -> ACK_N stays 1, BUSY stays 0.
  - ADDR=32'h11F -> ACK returned and index 31 is written.
- Held strobe: after ACK, master keeps AS_N low for 5 extra cycles -> exactly one ACK pulse and BUSY high until AS_N rises, then IDLE.
- Abort: AS_N raised during WAIT of a write to ADDR=7 (WAIT_STATES=4) -> no ACK; mem[7] unchanged (DBG_DATA check).
- Async reset mid-WAIT: RESET_N low mid-cycle -> ACK_N=1, BUSY=0, DO=0 immediately without a clock edge; previously written mem[3] still DEAD_BEEF.

Source files
------------

// File: rtl/dlx_bus_pkg.sv
// Shared types and constants for the DLX handshake bus slave.
// The state enum, default bus widths and the wait-state ceiling live here.
package dlx_bus_pkg;

   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;
   localparam int WAIT_MAX   = 15;
   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK,
      ST_DONE
   } busState_e;

endpackage

// File: rtl/dlx_bus_regfile.sv
// Word-addressed storage for the bus slave.
// Provides one write port, a registered read port feeding DO, and a combinational debug peek.
module dlx_bus_regfile #(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_wrEn,
   input  logic [DEPTH_LOG2-1:0] i_wrAddr,
   input  logic [DATA_W-1:0]     i_wrData,
   input  logic                  i_rdEn,
   input  logic [DEPTH_LOG2-1:0] i_rdAddr,
   output logic [DATA_W-1:0]     o_rdData,
   input  logic [DEPTH_LOG2-1:0] i_dbgAddr,
   output logic [DATA_W-1:0]     o_dbgData
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdData;

   // Contents survive reset, so the array has no reset branch.
   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdData <= '0;
      end else if (i_rdEn) begin
         r_rdData <= r_mem[i_rdAddr];
      end
   end

   assign o_rdData  = r_rdData;
   assign o_dbgData = r_mem[i_dbgAddr];

endmodule

// File: rtl/dlx_bus_slave.sv
// Responder for the DLX master's AS_N/WR_N/ACK_N bus: decodes an address window,
// inserts WAIT_STATES idle cycles, then acknowledges for exactly one cycle.
module dlx_bus_slave
   import dlx_bus_pkg::*;
#(
   parameter int                ADDR_W      = BUS_ADDR_W,
   parameter int                DATA_W      = BUS_DATA_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                DEPTH_LOG2  = 5,
   parameter int                WAIT_STATES = 2
) (
   input  logic                  CLK_IN,
   input  logic                  RESET_N,
   input  logic                  AS_N,
   input  logic                  WR_N,
   input  logic [ADDR_W-1:0]     ADDR,
   input  logic [DATA_W-1:0]     DI,
   output logic [DATA_W-1:0]     DO,
   output logic                  ACK_N,
   output logic                  BUSY,
   input  logic [DEPTH_LOG2-1:0] DBG_ADDR,
   output logic [DATA_W-1:0]     DBG_DATA
);

   localparam int                    LP_WAIT_INT = (WAIT_STATES > WAIT_MAX) ? WAIT_MAX : WAIT_STATES;
   localparam logic [WAIT_CNT_W-1:0] LP_WAIT     = WAIT_CNT_W'(LP_WAIT_INT);

   busState_e               r_state, w_nextState;
   logic [WAIT_CNT_W-1:0]   r_waitCnt, w_nextWaitCnt;
   logic [DEPTH_LOG2-1:0]   r_index, w_nextIndex;
   logic                    r_wrN, w_nextWrN;
   logic                    r_ackN;
   logic                    r_busy;

   logic [ADDR_W-1:0]       w_offset;
   logic                    w_hit;
   logic [DEPTH_LOG2-1:0]   w_reqIndex;
   logic                    w_rdEn;
   logic                    w_wrEn;
   logic [DATA_W-1:0]       w_rdData;

   // Unsigned wrap-around subtraction makes windows near the top of the address space work unchanged.
   assign w_offset   = ADDR - BASE_ADDR;
   assign w_hit      = (w_offset >> DEPTH_LOG2) == '0;
   assign w_reqIndex = w_offset[DEPTH_LOG2-1:0];

   always_comb begin
      w_nextState   = r_state;
      w_nextWaitCnt = r_waitCnt;
      w_nextIndex   = r_index;
      w_nextWrN     = r_wrN;
      unique case (r_state)
         ST_IDLE: begin
            if (!AS_N && w_hit) begin
               w_nextIndex = w_reqIndex;
               w_nextWrN   = WR_N;
               if (LP_WAIT == '0) begin
                  w_nextState = ST_ACK;
               end else begin
                  w_nextWaitCnt = LP_WAIT;
                  w_nextState   = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (AS_N) begin
               w_nextState   = ST_IDLE;
               w_nextWaitCnt = '0;
            end else if (r_waitCnt == WAIT_CNT_W'(1)) begin
               w_nextState   = ST_ACK;
               w_nextWaitCnt = '0;
            end else begin
               w_nextWaitCnt = r_waitCnt - WAIT_CNT_W'(1);
            end
         end
         ST_ACK: begin
            w_nextState = ST_DONE;
         end
         ST_DONE: begin
            if (AS_N) begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_IN or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state   <= ST_IDLE;
         r_waitCnt <= '0;
         r_index   <= '0;
         r_wrN     <= 1'b1;
         r_ackN    <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_waitCnt <= w_nextWaitCnt;
         r_index   <= w_nextIndex;
         r_wrN     <= w_nextWrN;
         r_ackN    <= (w_nextState != ST_ACK);
         r_busy    <= (w_nextState != ST_IDLE);
      end
   end

   // Read data is captured on the edge that enters ACK; writes commit on the edge that leaves it.
   assign w_rdEn = (w_nextState == ST_ACK) && w_nextWrN;
   assign w_wrEn = (r_state == ST_ACK) && !r_wrN;

   dlx_bus_regfile #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_regfile (
      .clk       (CLK_IN),
      .rst_n     (RESET_N),
      .i_wrEn    (w_wrEn),
      .i_wrAddr  (r_index),
      .i_wrData  (DI),
      .i_rdEn    (w_rdEn),
      .i_rdAddr  (w_nextIndex),
      .o_rdData  (w_rdData),
      .i_dbgAddr (DBG_ADDR),
      .o_dbgData (DBG_DATA)
   );

   assign DO    = w_rdData;
   assign ACK_N = r_ackN;
   assign BUSY  = r_busy;

endmodule

// File: tb/tb_dlx_bus_slave.sv
// Scoreboard bench for dlx_bus_slave: three instances with different windows and wait counts,
// a driver that queues expected acknowledges, and a monitor that checks every ACK_N pulse.
module tb_dlx_bus_slave;

   localparam int NI = 3;
   localparam logic [31:0] BASES [NI] = '{32'h0000_0000, 32'h0000_0100, 32'hFFFF_FFF0};
   localparam int          WSS   [NI] = '{2, 0, 4};

   typedef struct {
      int          inst;
      int          ackEdge;
      bit          isRead;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        rstN;
   logic        asN     [NI];
   logic        wrN     [NI];
   logic [31:0] addr    [NI];
   logic [31:0] di      [NI];
   logic [31:0] dout    [NI];
   logic        ackN    [NI];
   logic        busy    [NI];
   logic [4:0]  dbgAddr [NI];
   logic [31:0] dbgData [NI];

   logic [31:0] model [NI][32];
   exp_t        sbq [$];
   int          edgeCnt = 0;
   int          nChecks = 0;
   int          nFail   = 0;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      dlx_bus_slave #(
         .ADDR_W      (32),
         .DATA_W      (32),
         .BASE_ADDR   (BASES[g]),
         .DEPTH_LOG2  (5),
         .WAIT_STATES (WSS[g])
      ) u_dut (
         .CLK_IN   (clk),
         .RESET_N  (rstN),
         .AS_N     (asN[g]),
         .WR_N     (wrN[g]),
         .ADDR     (addr[g]),
         .DI       (di[g]),
         .DO       (dout[g]),
         .ACK_N    (ackN[g]),
         .BUSY     (busy[g]),
         .DBG_ADDR (dbgAddr[g]),
         .DBG_DATA (dbgData[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edgeCnt++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkDbg(input int k, input int idx);
      dbgAddr[k] = 5'(idx);
      #1;
      checkOutput($sformatf("dbgData[%0d][%0d]", k, idx), dbgData[k], model[k][idx]);
   endtask

   // Every ACK_N pulse must match the oldest queued expectation in instance, edge and read data.
   always @(negedge clk) begin
      if (rstN === 1'b1) begin
         for (int k = 0; k < NI; k++) begin
            if (ackN[k] === 1'b0) begin
               if (sbq.size() == 0) begin
                  nChecks++;
                  nFail++;
                  $display("[TB] FAIL spuriousAck inst=%0d actual ACK_N=0 expected ACK_N=1 (t=%0t)", k, $time);
               end else begin
                  exp_t e;
                  e = sbq.pop_front();
                  checkOutput("ackInst", k, e.inst);
                  checkOutput("ackLatency", edgeCnt, e.ackEdge);
                  if (e.isRead) checkOutput("readData", dout[k], e.data);
               end
            end
         end
      end
   end

   // One master bus cycle; extra holds AS_N low for that many cycles beyond the normal DONE cycle.
   task automatic applyStimulus(input int k, input bit wr, input logic [31:0] a,
                                input logic [31:0] d, input int extra);
      logic [31:0] off;
      int          idx;
      bit          seen;
      exp_t        e;
      off = a - BASES[k];
      idx = int'(off[4:0]);
      @(negedge clk);
      asN[k] = 1'b0;
      wrN[k] = !wr;
      addr[k] = a;
      di[k] = d;
      if (off < 32) begin
         e.inst    = k;
         e.ackEdge = edgeCnt + 1 + WSS[k];
         e.isRead  = !wr;
         e.data    = model[k][idx];
         sbq.push_back(e);
         if (wr) model[k][idx] = d;
         seen = 1'b0;
         for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (ackN[k] === 1'b0) seen = 1'b1;
         end
         checkOutput("ackArrived", 32'(seen), 32'd1);
         if (!seen) sbq.delete();
         for (int h = 0; h <= extra; h++) begin
            @(negedge clk);
            checkOutput("busyInDone", busy[k], 1'b1);
            checkOutput("ackOnce", ackN[k], 1'b1);
         end
         asN[k] = 1'b1;
         @(negedge clk);
         checkOutput("busyRelease", busy[k], 1'b0);
      end else begin
         for (int h = 0; h < 4 + extra; h++) begin
            @(negedge clk);
            checkOutput("missAck", ackN[k], 1'b1);
            checkOutput("missBusy", busy[k], 1'b0);
         end
         asN[k] = 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rstN = 1'b0;
      for (int k = 0; k < NI; k++) begin
         asN[k] = 1'b1;
         wrN[k] = 1'b1;
         addr[k] = '0;
         di[k] = '0;
         dbgAddr[k] = '0;
      end
      #12;
      for (int k = 0; k < NI; k++) begin
         checkOutput("rstAck", ackN[k], 1'b1);
         checkOutput("rstBusy", busy[k], 1'b0);
         checkOutput("rstDo", dout[k], 32'h0);
      end
      @(negedge clk);
      rstN = 1'b1;

      for (int k = 0; k < NI; k++)
         for (int i = 0; i < 32; i++)
            applyStimulus(k, 1'b1, BASES[k] + 32'(i), $urandom, 0);

      applyStimulus(0, 1'b1, 32'd3, 32'hDEAD_BEEF, 0);
      checkDbg(0, 3);
      applyStimulus(0, 1'b0, 32'd3, 32'h0, 0);

      // Reset in the middle of a write's wait phase.
      @(negedge clk);
      asN[0] = 1'b0;
      wrN[0] = 1'b0;
      addr[0] = 32'd5;
      di[0] = ~model[0][5];
      @(negedge clk);
      #2 rstN = 1'b0;
      #1;
      checkOutput("asyncRstAck", ackN[0], 1'b1);
      checkOutput("asyncRstBusy", busy[0], 1'b0);
      checkOutput("asyncRstDo", dout[0], 32'h0);
      asN[0] = 1'b1;
      @(negedge clk);
      rstN = 1'b1;
      checkDbg(0, 3);
      checkDbg(0, 5);

      applyStimulus(1, 1'b1, 32'h100, 32'h1, 0);
      checkDbg(1, 0);
      applyStimulus(1, 1'b1, 32'h120, 32'hCAFE_0001, 6);
      applyStimulus(1, 1'b1, 32'h11F, 32'h5A5A_1F1F, 0);
      checkDbg(1, 31);

      applyStimulus(0, 1'b0, 32'd3, 32'h0, 5);

      // Abandoned write on the wrapped window: ADDR 7 is offset 23 from 0xFFFF_FFF0.
      @(negedge clk);
      asN[2] = 1'b0;
      wrN[2] = 1'b0;
      addr[2] = 32'd7;
      di[2] = ~model[2][23];
      @(negedge clk);
      checkOutput("abortBusy", busy[2], 1'b1);
      @(negedge clk);
      asN[2] = 1'b1;
      repeat (8) @(negedge clk);
      checkOutput("abortIdle", busy[2], 1'b0);
      checkDbg(2, 23);

      for (int t = 0; t < 60; t++) begin
         int k;
         k = $urandom_range(0, NI - 1);
         applyStimulus(k, 1'($urandom_range(0, 1)), BASES[k] + 32'($urandom_range(0, 39)),
                       $urandom, $urandom_range(0, 2));
      end
      for (int k = 0; k < NI; k++) checkDbg(k, $urandom_range(0, 31));

      repeat (3) @(negedge clk);
      checkOutput("sbqDrained", sbq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
